// File: rtl/case_decode_pipe.sv
// Registered multi-channel value-to-code decoder driven by a runtime-writable lookup table.
// Misses either repeat the channel's last hit code or emit DEF_CODE, and are flagged and counted.
module case_decode_pipe #(
    parameter int                DATA_W       = 4,
    parameter int                CODE_W       = 3,
    parameter int                CH           = 2,
    parameter logic [CODE_W-1:0] DEF_CODE     = '0,
    parameter bit                HOLD_ON_MISS = 1'b1,
    parameter int                MCNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [DATA_W-1:0]    cfg_addr,
    input  logic [CODE_W-1:0]    cfg_code,
    input  logic                 cfg_vld,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*DATA_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*CODE_W-1:0] out_code,
    output logic [CH-1:0]        out_miss,
    input  logic                 miss_clr,
    output logic [MCNT_W-1:0]    miss_cnt
);

    localparam int DEPTH = 2 ** DATA_W;

    logic [CODE_W-1:0]    r_tblCode [DEPTH];
    logic [DEPTH-1:0]     r_tblVld;
    logic [CODE_W-1:0]    r_held [CH];
    logic                 r_outValid;
    logic [CH*CODE_W-1:0] r_outCode;
    logic [CH-1:0]        r_outMiss;
    logic [MCNT_W-1:0]    r_missCnt;

    logic                 w_accept;
    logic [CH*CODE_W-1:0] w_nextCode;
    logic [CH-1:0]        w_nextMiss;
    logic [MCNT_W:0]      w_missAdd;
    logic [MCNT_W:0]      w_missSum;

    assign in_ready  = !r_outValid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_outValid;
    assign out_code  = r_outCode;
    assign out_miss  = r_outMiss;
    assign miss_cnt  = r_missCnt;

    // Lookup reads the registered table, so a same-cycle write is only seen by later beats.
    always_comb begin
        w_nextCode = '0;
        w_nextMiss = '0;
        w_missAdd  = '0;
        for (int c = 0; c < CH; c++) begin
            if (r_tblVld[in_data[c*DATA_W +: DATA_W]]) begin
                w_nextCode[c*CODE_W +: CODE_W] = r_tblCode[in_data[c*DATA_W +: DATA_W]];
            end else begin
                w_nextMiss[c] = 1'b1;
                w_nextCode[c*CODE_W +: CODE_W] = HOLD_ON_MISS ? r_held[c] : DEF_CODE;
            end
            w_missAdd = w_missAdd + (MCNT_W+1)'(w_nextMiss[c]);
        end
        w_missSum = {1'b0, r_missCnt} + w_missAdd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tblVld[i]  <= (i == 0) || (i >= 8 && i <= 11);
                r_tblCode[i] <= (i == 0) ? CODE_W'(1) :
                                (i >= 8 && i <= 11) ? CODE_W'(3) : '0;
            end
        end else if (cfg_we) begin
            r_tblCode[cfg_addr] <= cfg_code;
            r_tblVld[cfg_addr]  <= cfg_vld;
        end
    end

    // Output stage holds its beat while stalled; a clear overrides that cycle's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_outCode  <= '0;
            r_outMiss  <= '0;
            r_missCnt  <= '0;
            for (int c = 0; c < CH; c++) begin
                r_held[c] <= DEF_CODE;
            end
        end else begin
            if (in_ready) begin
                r_outValid <= in_valid;
            end
            if (w_accept) begin
                r_outCode <= w_nextCode;
                r_outMiss <= w_nextMiss;
                for (int c = 0; c < CH; c++) begin
                    if (!w_nextMiss[c]) begin
                        r_held[c] <= w_nextCode[c*CODE_W +: CODE_W];
                    end
                end
            end
            if (miss_clr) begin
                r_missCnt <= '0;
            end else if (w_accept) begin
                r_missCnt <= w_missSum[MCNT_W] ? '1 : w_missSum[MCNT_W-1:0];
            end
        end
    end

endmodule
